// File: rtl/bounce_counter_nbit.sv
// Bounded up/down counter with runtime step, load, and wrap/saturate/bounce/hold boundary modes.
// Optional prescaler on enabled cycles is built only when COUNTER_PRESCALE_EN is defined.
module bounce_counter_nbit #(
    parameter int WIDTH      = 10,
    parameter int MIN_VALUE  = 0,
    parameter int MAX_VALUE  = 2**WIDTH - 1,
    parameter int STEP_WIDTH = 4,
    parameter int PRESCALE   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic                  load,
    input  logic [WIDTH-1:0]      loadValue,
    input  logic                  loadDown,
    output logic [WIDTH-1:0]      countValue,
    output logic                  down,
    output logic                  atMax,
    output logic                  atMin,
    output logic                  boundaryHit
);

    typedef enum logic [1:0] {
        MODE_WRAP   = 2'b00,
        MODE_SAT    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    // Signed arithmetic domain wide enough for count + step and count - step without aliasing.
    localparam int EW = ((WIDTH > STEP_WIDTH) ? WIDTH : STEP_WIDTH) + 2;

    localparam logic [WIDTH-1:0] MIN_L = WIDTH'(MIN_VALUE);
    localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_VALUE);

    if (PRESCALE < 1 || MIN_VALUE < 0 || MIN_VALUE > MAX_VALUE || MAX_VALUE >= 2**WIDTH) begin : g_param_check
        $error("bounce_counter_nbit: invalid parameter combination");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             down_q, down_d;
    logic             hit_q, hit_d;
    logic             advance;
    mode_e            mode_s;

    logic signed [EW-1:0] cnt_x, step_x, ld_x, min_x, max_x, up_x, dn_x;

    assign mode_s = mode_e'(mode);
    assign cnt_x  = $signed({{(EW-WIDTH){1'b0}}, count_q});
    assign step_x = $signed({{(EW-STEP_WIDTH){1'b0}}, step});
    assign ld_x   = $signed({{(EW-WIDTH){1'b0}}, loadValue});
    assign min_x  = $signed({{(EW-WIDTH){1'b0}}, MIN_L});
    assign max_x  = $signed({{(EW-WIDTH){1'b0}}, MAX_L});
    assign up_x   = cnt_x + step_x;
    assign dn_x   = cnt_x - step_x;

`ifdef COUNTER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] pre_q, pre_d;
    logic          pre_wrap;

    assign pre_wrap = (pre_q == PW'(PRESCALE - 1));
    assign advance  = enable && pre_wrap;

    always_comb begin
        pre_d = pre_q;
        if (load) begin
            pre_d = '0;
        end else if (enable) begin
            pre_d = pre_wrap ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign advance = enable;
`endif

    always_comb begin
        count_d = count_q;
        down_d  = down_q;
        hit_d   = 1'b0;
        if (load) begin
            down_d = loadDown;
            if (ld_x < min_x) begin
                count_d = MIN_L;
            end else if (ld_x > max_x) begin
                count_d = MAX_L;
            end else begin
                count_d = loadValue;
            end
        end else if (advance && step != '0 && mode_s != MODE_HOLD) begin
            if (!down_q) begin
                if (up_x >= max_x) begin
                    hit_d = 1'b1;
                    unique case (mode_s)
                        MODE_WRAP:   count_d = MIN_L;
                        MODE_SAT:    count_d = MAX_L;
                        MODE_BOUNCE: begin
                            count_d = MAX_L;
                            down_d  = 1'b1;
                        end
                        default:     count_d = count_q;
                    endcase
                end else begin
                    count_d = WIDTH'(up_x);
                end
            end else begin
                if (dn_x <= min_x) begin
                    hit_d = 1'b1;
                    unique case (mode_s)
                        MODE_WRAP:   count_d = MAX_L;
                        MODE_SAT:    count_d = MIN_L;
                        MODE_BOUNCE: begin
                            count_d = MIN_L;
                            down_d  = 1'b0;
                        end
                        default:     count_d = count_q;
                    endcase
                end else begin
                    count_d = WIDTH'(dn_x);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= MIN_L;
            down_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            down_q  <= down_d;
            hit_q   <= hit_d;
        end
    end

    assign countValue  = count_q;
    assign down        = down_q;
    assign boundaryHit = hit_q;
    assign atMax       = (count_q == MAX_L);
    assign atMin       = (count_q == MIN_L);

endmodule

// File: tb/tb_bounce_counter_nbit.sv
// Bench for bounce_counter_nbit: integer reference model checked every cycle, plus literal pins.
// Build with +define+COUNTER_PRESCALE_EN to exercise the prescaler variant.
module tb_bounce_counter_nbit;

    localparam int W    = 4;
    localparam int MINV = 2;
    localparam int MAXV = 12;
    localparam int SW   = 4;
    localparam int PS   = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [SW-1:0] step = '0;
    logic          load = 1'b0;
    logic [W-1:0]  loadValue = '0;
    logic          loadDown = 1'b0;
    logic [W-1:0]  countValue;
    logic          down, atMax, atMin, boundaryHit;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    int m_cnt = MINV, m_down = 0, m_hit = 0, m_pre = 0;

    bounce_counter_nbit #(
        .WIDTH(W), .MIN_VALUE(MINV), .MAX_VALUE(MAXV), .STEP_WIDTH(SW), .PRESCALE(PS)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode), .step(step),
        .load(load), .loadValue(loadValue), .loadDown(loadDown),
        .countValue(countValue), .down(down), .atMax(atMax), .atMin(atMin),
        .boundaryHit(boundaryHit)
    );

    always #5 clock = ~clock;

    // Reference: plain integer arithmetic, no width limits, so crossing past MAX never aliases.
    always @(posedge clock) begin
        int nxt;
        bit adv;
        if (reset) begin
            m_cnt = MINV; m_down = 0; m_hit = 0; m_pre = 0;
        end else if (load) begin
            m_cnt  = (int'(loadValue) < MINV) ? MINV : (int'(loadValue) > MAXV) ? MAXV : int'(loadValue);
            m_down = int'(loadDown);
            m_hit  = 0;
            m_pre  = 0;
        end else if (enable) begin
            m_hit = 0;
            adv   = 1'b1;
`ifdef COUNTER_PRESCALE_EN
            m_pre = m_pre + 1;
            adv   = (m_pre == PS);
            if (adv) m_pre = 0;
`endif
            if (adv && step != 0 && mode != 2'd3) begin
                if (m_down == 0) begin
                    nxt = m_cnt + int'(step);
                    if (nxt >= MAXV) begin
                        m_hit = 1;
                        m_cnt = (mode == 2'd0) ? MINV : MAXV;
                        if (mode == 2'd2) m_down = 1;
                    end else m_cnt = nxt;
                end else begin
                    nxt = m_cnt - int'(step);
                    if (nxt <= MINV) begin
                        m_hit = 1;
                        m_cnt = (mode == 2'd0) ? MAXV : MINV;
                        if (mode == 2'd2) m_down = 0;
                    end else m_cnt = nxt;
                end
            end
        end else begin
            m_hit = 0;
        end
    end

    task automatic cmp(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_on) begin
            cmp("count",   int'(countValue),  m_cnt);
            cmp("down",    int'(down),        m_down);
            cmp("hit",     int'(boundaryHit), m_hit);
            cmp("atMax",   int'(atMax),       int'(m_cnt == MAXV));
            cmp("atMin",   int'(atMin),       int'(m_cnt == MINV));
        end
    end

    task automatic tick(input int r, input int ld, input int lv, input int ldn,
                        input int en, input int md, input int st);
        reset     = r[0];
        load      = ld[0];
        loadValue = W'(lv);
        loadDown  = ldn[0];
        enable    = en[0];
        mode      = md[1:0];
        step      = SW'(st);
        @(posedge clock);
        #1;
    endtask

    // Pins both the DUT and the model to a hand-computed value.
    task automatic lit(input string name, input int c, input int d, input int h);
        cmp({name, ".cnt"},   int'(countValue),  c);
        cmp({name, ".down"},  int'(down),        d);
        cmp({name, ".hit"},   int'(boundaryHit), h);
        cmp({name, ".model"}, m_cnt * 4 + m_down * 2 + m_hit, c * 4 + d * 2 + h);
    endtask

    initial begin
        tick(1, 0, 0, 0, 0, 0, 0);
        chk_on = 1'b1;
        tick(1, 0, 0, 0, 1, 0, 3);
        lit("reset", 2, 0, 0);
        cmp("reset.atMin", int'(atMin), 1);

`ifndef COUNTER_PRESCALE_EN
        // Wrap, step 3: 5, 8, 11, then 14 crosses MAX -> back to MIN with a hit.
        tick(0, 0, 0, 0, 1, 0, 3); lit("wrap1", 5, 0, 0);
        tick(0, 0, 0, 0, 1, 0, 3); lit("wrap2", 8, 0, 0);
        tick(0, 0, 0, 0, 1, 0, 3); lit("wrap3", 11, 0, 0);
        tick(0, 0, 0, 0, 1, 0, 3); lit("wrap4", 2, 0, 1);
        tick(0, 0, 0, 0, 1, 0, 3); lit("wrap5", 5, 0, 0);

        // Bounce, step 4 from 10 up.
        tick(0, 1, 10, 0, 0, 2, 4); lit("bload", 10, 0, 0);
        tick(0, 0, 0, 0, 1, 2, 4);  lit("b1", 12, 1, 1);
        tick(0, 0, 0, 0, 1, 2, 4);  lit("b2", 8, 1, 0);
        tick(0, 0, 0, 0, 1, 2, 4);  lit("b3", 4, 1, 0);
        tick(0, 0, 0, 0, 1, 2, 4);  lit("b4", 2, 0, 1);
        tick(0, 0, 0, 0, 1, 2, 4);  lit("b5", 6, 0, 0);

        // Saturate at MAX keeps hitting.
        tick(0, 1, 9, 0, 0, 1, 5); lit("sload", 9, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, 1, 1, 5);
            lit("sat", 12, 0, 1);
            cmp("sat.atMax", int'(atMax), 1);
        end

        // Load beats enable and clamps; reset beats load.
        tick(0, 1, 15, 0, 1, 0, 3); lit("clampHi", 12, 0, 0);
        tick(0, 1, 0, 1, 1, 0, 3);  lit("clampLo", 2, 1, 0);
        tick(1, 1, 7, 1, 1, 0, 3);  lit("rstLoad", 2, 0, 0);

        // step 0 and hold mode do nothing.
        tick(0, 1, 7, 0, 0, 0, 0); lit("hload", 7, 0, 0);
        tick(0, 0, 0, 0, 1, 0, 0); lit("step0", 7, 0, 0);
        tick(0, 0, 0, 0, 1, 3, 5); lit("hold", 7, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 5); lit("noen", 7, 0, 0);

        // Down wrap lands on MIN -> MAX; huge step from MIN must not alias in 4 bits.
        tick(0, 1, 5, 1, 0, 0, 3); lit("dload", 5, 1, 0);
        tick(0, 0, 0, 0, 1, 0, 3); lit("dwrap", 12, 1, 1);
        tick(0, 1, 2, 0, 0, 1, 15); lit("bigload", 2, 0, 0);
        tick(0, 0, 0, 0, 1, 1, 15); lit("bigstep", 12, 0, 1);
        tick(0, 0, 0, 0, 1, 0, 10); lit("landMax", 2, 0, 1);
`else
        // One advance per PS enabled cycles; a load restarts the phase.
        for (int i = 0; i < PS - 1; i++) begin
            tick(0, 0, 0, 0, 1, 0, 1); lit("pre.wait", 2, 0, 0);
        end
        tick(0, 0, 0, 0, 1, 0, 1); lit("pre.adv", 3, 0, 0);
        tick(0, 0, 0, 0, 1, 0, 1);
        tick(0, 0, 0, 0, 0, 0, 1);
        tick(0, 1, 8, 0, 0, 0, 1); lit("pre.load", 8, 0, 0);
        for (int i = 0; i < PS - 1; i++) begin
            tick(0, 0, 0, 0, 1, 0, 1); lit("pre.wait2", 8, 0, 0);
        end
        tick(0, 0, 0, 0, 1, 0, 1); lit("pre.adv2", 9, 0, 0);
`endif

        // Random enable/mode/step/load traffic checked by the model.
        for (int i = 0; i < 200; i++) begin
            tick(0, ($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(0, 15),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                 $urandom_range(0, 15));
        end
        tick(0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
